// File: rtl/shift_pkg.sv
// Shared definitions for the shift dispatcher: format codes, sequencer states,
// and the packed request record width.
package shift_pkg;

  localparam logic [2:0] FMT_LSR = 3'd0;
  localparam logic [2:0] FMT_LSL = 3'd1;
  localparam logic [2:0] FMT_ASR = 3'd2;
  localparam logic [2:0] FMT_ASL = 3'd3;
  localparam logic [2:0] FMT_ROR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Record layout, MSB first: {fmt[2:0], cnt[5:0], a[31:0], tag[TAGW-1:0]}
  function automatic int req_rec_w(input int tagw);
    return 3 + 6 + 32 + tagw;
  endfunction

  function automatic logic fmt_reserved(input logic [2:0] fmt);
    return fmt > FMT_ROR;
  endfunction

endpackage

// File: rtl/shift_dispatch_if.sv
// Bus bundle between core, dispatcher and shifter. The dispatcher takes the
// slave modport; the core/shifter environment takes the master modport.
interface shift_dispatch_if #(
  parameter int TAGW = 4
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both 1; the sender holds valid and payload stable until that edge.
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_fmt;
  logic [5:0]      req_cnt;
  logic [31:0]     req_a;
  logic [TAGW-1:0] req_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_y;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  logic            sh_go;
  logic [2:0]      sh_fmt;
  logic [5:0]      sh_cnt;
  logic [31:0]     sh_a;
  logic            sh_busy;
  logic [31:0]     sh_y;

  modport slave (
    input  req_valid, req_fmt, req_cnt, req_a, req_tag,
    output req_ready,
    output rsp_valid, rsp_y, rsp_tag, rsp_err,
    input  rsp_ready,
    output sh_go, sh_fmt, sh_cnt, sh_a,
    input  sh_busy, sh_y
  );

  modport master (
    output req_valid, req_fmt, req_cnt, req_a, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_y, rsp_tag, rsp_err,
    output rsp_ready,
    input  sh_go, sh_fmt, sh_cnt, sh_a,
    output sh_busy, sh_y
  );

endinterface

// File: rtl/shift_req_fifo.sv
// Synchronous request FIFO, DEPTH (power of 2) entries of W bits, with
// full/empty flags; push and pop in the same cycle are accepted when full.
module shift_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 45
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_dispatch.sv
// Request queue and sequencer in front of the iterative shifter.
// Optional zero-shift bypass: define SHIFT_DISPATCH_BYPASS_EN.
module shift_dispatch
  import shift_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAGW   = 4,
  parameter int ARM_TO = 3
) (
  input  logic             clk,
  input  logic             arstn,
  shift_dispatch_if.slave  bus,
  output state_t           o_dbg_state
);

  localparam int RW  = req_rec_w(TAGW);
  localparam int ACW = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_sh_fmt, w_sh_fmt_nxt;
  logic [5:0]      r_sh_cnt, w_sh_cnt_nxt;
  logic [31:0]     r_sh_a, w_sh_a_nxt;
  logic [TAGW-1:0] r_tag, w_tag_nxt;
  logic [31:0]     r_rsp_y, w_rsp_y_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic [ACW-1:0]  r_arm_cnt, w_arm_cnt_nxt;
  logic            r_rst_done;

  logic            w_push;
  logic            w_pop;
  logic            w_take;
  logic            w_full;
  logic            w_empty;
  logic [RW-1:0]   w_in_rec;
  logic [RW-1:0]   w_head;
  logic [2:0]      w_h_fmt;
  logic [5:0]      w_h_cnt;
  logic [31:0]     w_h_a;
  logic [TAGW-1:0] w_h_tag;
  logic            w_skip;

  assign w_in_rec = {bus.req_fmt, bus.req_cnt, bus.req_a, bus.req_tag};
  assign w_push   = bus.req_valid & bus.req_ready;

  shift_req_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .i_push  (w_push),
    .i_data  (w_in_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_h_fmt = w_head[RW-1 -: 3];
  assign w_h_cnt = w_head[RW-4 -: 6];
  assign w_h_a   = w_head[TAGW +: 32];
  assign w_h_tag = w_head[TAGW-1:0];

`ifdef SHIFT_DISPATCH_BYPASS_EN
  assign w_skip = (w_h_cnt == 6'd0) || ((w_h_fmt == FMT_ROR) && (w_h_cnt[4:0] == 5'd0));
`else
  assign w_skip = 1'b0;
`endif

  // req_ready stays low through reset and the first edge after it
  assign bus.req_ready = r_rst_done & ~w_full;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_tag   = r_tag;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.sh_go     = (r_state == ST_LAUNCH);
  assign bus.sh_fmt    = r_sh_fmt;
  assign bus.sh_cnt    = r_sh_cnt;
  assign bus.sh_a      = r_sh_a;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_state_nxt   = r_state;
    w_sh_fmt_nxt  = r_sh_fmt;
    w_sh_cnt_nxt  = r_sh_cnt;
    w_sh_a_nxt    = r_sh_a;
    w_tag_nxt     = r_tag;
    w_rsp_y_nxt   = r_rsp_y;
    w_rsp_err_nxt = r_rsp_err;
    w_arm_cnt_nxt = r_arm_cnt;
    w_take        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_take = 1'b1;
      end
      ST_LAUNCH: begin
        w_state_nxt   = ST_ARM;
        w_arm_cnt_nxt = '0;
      end
      ST_ARM: begin
        // A shifter that never raises busy is treated as finished after ARM_TO cycles
        if (bus.sh_busy) begin
          w_state_nxt = ST_WAIT;
        end else if (r_arm_cnt == ACW'(ARM_TO - 1)) begin
          w_rsp_y_nxt   = bus.sh_y;
          w_rsp_err_nxt = 1'b0;
          w_state_nxt   = ST_RESP;
        end else begin
          w_arm_cnt_nxt = r_arm_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.sh_busy) begin
          w_rsp_y_nxt   = bus.sh_y;
          w_rsp_err_nxt = 1'b0;
          w_state_nxt   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          if (!w_empty) w_take = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Pop the head; shared by IDLE and the back-to-back path out of RESP
    if (w_take) begin
      w_tag_nxt = w_h_tag;
      if (fmt_reserved(w_h_fmt)) begin
        w_rsp_y_nxt   = w_h_a;
        w_rsp_err_nxt = 1'b1;
        w_state_nxt   = ST_RESP;
      end else if (w_skip) begin
        w_rsp_y_nxt   = w_h_a;
        w_rsp_err_nxt = 1'b0;
        w_state_nxt   = ST_RESP;
      end else begin
        w_sh_fmt_nxt = w_h_fmt;
        w_sh_cnt_nxt = w_h_cnt;
        w_sh_a_nxt   = w_h_a;
        w_state_nxt  = ST_LAUNCH;
      end
    end
  end

  assign w_pop = w_take;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= ST_IDLE;
      r_sh_fmt   <= '0;
      r_sh_cnt   <= '0;
      r_sh_a     <= '0;
      r_tag      <= '0;
      r_rsp_y    <= '0;
      r_rsp_err  <= 1'b0;
      r_arm_cnt  <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh_fmt   <= w_sh_fmt_nxt;
      r_sh_cnt   <= w_sh_cnt_nxt;
      r_sh_a     <= w_sh_a_nxt;
      r_tag      <= w_tag_nxt;
      r_rsp_y    <= w_rsp_y_nxt;
      r_rsp_err  <= w_rsp_err_nxt;
      r_arm_cnt  <= w_arm_cnt_nxt;
      r_rst_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_dispatch.sv
// Bench for shift_dispatch with a behavioural iterative-shifter model on the
// sh_* port; directed vector table plus multi-cycle sequences.
module tb_shift_dispatch;
  import shift_pkg::*;

  localparam int TAGW = 4;

`ifdef SHIFT_DISPATCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   arstn = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  shift_dispatch_if #(.TAGW(TAGW)) bus ();

  shift_dispatch #(
    .DEPTH  (2),
    .TAGW   (TAGW),
    .ARM_TO (3)
  ) dut (
    .clk         (clk),
    .arstn       (arstn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int go_cnt = 0;
  int model_lat = 2;
  bit model_no_busy = 1'b0;

  logic [31:0]     exp_q[$];
  logic [TAGW-1:0] tag_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- shifter model ----------------
  function automatic logic [31:0] shift_ref(input logic [2:0] f, input logic [5:0] c,
                                            input logic [31:0] a);
    logic [63:0] t;
    case (f)
      FMT_LSR: return a >> c;
      FMT_LSL, FMT_ASL: return a << c;
      FMT_ASR: return 32'($signed(a) >>> c);
      default: begin
        t = {a, a} >> c[4:0];
        return t[31:0];
      end
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [5:0]  c;
    logic [31:0] a;
    bus.sh_busy = 1'b0;
    bus.sh_y    = '0;
    forever begin
      @(negedge clk);
      if (arstn && bus.sh_go) begin
        f = bus.sh_fmt;
        c = bus.sh_cnt;
        a = bus.sh_a;
        if (model_no_busy) begin
          bus.sh_y = shift_ref(f, c, a);
        end else begin
          bus.sh_busy = 1'b1;
          for (int k = 0; k < model_lat; k++) begin
            @(negedge clk);
            if (!arstn) break;
          end
          if (arstn) begin
            check("sh_inputs_stable", {23'd0, bus.sh_fmt, bus.sh_cnt, bus.sh_a}, {23'd0, f, c, a});
            bus.sh_y = shift_ref(f, c, a);
          end
          bus.sh_busy = 1'b0;
        end
      end
    end
  end

  // go pulse monitor, sampled just after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.sh_go) begin
        go_cnt++;
        check("go_while_busy", 64'(bus.sh_busy), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [2:0] f, input logic [5:0] c, input logic [31:0] a,
                          input logic [TAGW-1:0] t);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_fmt   = f;
    bus.req_cnt   = c;
    bus.req_a     = a;
    bus.req_tag   = t;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("req_accept");
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] ey, input logic [TAGW-1:0] et,
                         input logic ee);
    int n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timeout_fail(name);
    end else begin
      check({name, "_y"},   64'(bus.rsp_y),   64'(ey));
      check({name, "_tag"}, 64'(bus.rsp_tag), 64'(et));
      check({name, "_err"}, 64'(bus.rsp_err), 64'(ee));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]      fmt;
    logic [5:0]      cnt;
    logic [31:0]     a;
    logic [TAGW-1:0] tag;
    bit              no_busy;
    logic [31:0]     exp_y;
    bit              exp_err;
    int              exp_go;
  } vec_t;

  vec_t vecs[11];

  initial begin : main
    int g0;
    int seen;

    vecs[0]  = '{3'd0, 6'd8,  32'd1000000,   4'd1,  1'b0, 32'd3906,      1'b0, 1};
    vecs[1]  = '{3'd6, 6'd0,  32'h0000_1234, 4'd2,  1'b0, 32'h0000_1234, 1'b1, 0};
    vecs[2]  = '{3'd1, 6'd0,  32'd77,        4'd3,  1'b0, 32'd77,        1'b0, 1 - BYP};
    vecs[3]  = '{3'd3, 6'd5,  32'd3,         4'd4,  1'b0, 32'd96,        1'b0, 1};
    vecs[4]  = '{3'd4, 6'd36, 32'h1234_5678, 4'd5,  1'b0, 32'h8123_4567, 1'b0, 1};
    vecs[5]  = '{3'd4, 6'd32, 32'hDEAD_BEEF, 4'd6,  1'b0, 32'hDEAD_BEEF, 1'b0, 1 - BYP};
    vecs[6]  = '{3'd0, 6'd40, 32'hFFFF_FFFF, 4'd7,  1'b0, 32'h0000_0000, 1'b0, 1};
    vecs[7]  = '{3'd2, 6'd31, 32'h8000_0000, 4'd8,  1'b0, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[8]  = '{3'd1, 6'd31, 32'h0000_0001, 4'd9,  1'b1, 32'h8000_0000, 1'b0, 1};
    vecs[9]  = '{3'd7, 6'd3,  32'h0000_CAFE, 4'd10, 1'b0, 32'h0000_CAFE, 1'b1, 0};
    vecs[10] = '{3'd2, 6'd2,  32'h4000_0000, 4'd11, 1'b0, 32'h1000_0000, 1'b0, 1};

    bus.req_valid = 1'b0;
    bus.req_fmt   = '0;
    bus.req_cnt   = '0;
    bus.req_a     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_sh_go",     64'(bus.sh_go),     64'd0);
    check("rst_rsp_y",     64'(bus.rsp_y),     64'd0);
    check("rst_sh_a",      64'(bus.sh_a),      64'd0);
    check("rst_state",     64'(dbg_state),     64'(ST_IDLE));
    arstn = 1'b1;
    #1;
    check("rdy_before_edge", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("rdy_after_edge", 64'(bus.req_ready), 64'd1);

    // table-driven single ops
    for (int i = 0; i < 11; i++) begin
      g0 = go_cnt;
      model_no_busy = vecs[i].no_busy;
      send_req(vecs[i].fmt, vecs[i].cnt, vecs[i].a, vecs[i].tag);
      get_rsp($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].tag, vecs[i].exp_err);
      check($sformatf("vec%0d_go", i), 64'(go_cnt - g0), 64'(vecs[i].exp_go));
    end
    model_no_busy = 1'b0;

    // three back-to-back requests, FIFO fills
    model_lat = 3;
    g0 = go_cnt;
    exp_q.push_back(32'd160000);      tag_q.push_back(4'd12);
    exp_q.push_back(32'hFFFE_17B8);   tag_q.push_back(4'd13);
    exp_q.push_back(32'h5800_0040);   tag_q.push_back(4'd14);
    send_req(FMT_LSL, 6'd4, 32'd10000,       4'd12);
    send_req(FMT_ASR, 6'd3, 32'hFFF0_BDC0,   4'd13);
    send_req(FMT_ROR, 6'd4, 32'h8000_0405,   4'd14);
    check("full_req_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      get_rsp($sformatf("b2b%0d", i), exp_q.pop_front(), tag_q.pop_front(), 1'b0);
    end
    check("b2b_go", 64'(go_cnt - g0), 64'd3);

    // response stall: nothing new launches until accept
    model_lat = 2;
    g0 = go_cnt;
    exp_q.push_back(32'd10);   tag_q.push_back(4'd1);
    exp_q.push_back(32'h10);   tag_q.push_back(4'd2);
    send_req(FMT_LSL, 6'd1, 32'd5,     4'd1);
    send_req(FMT_LSR, 6'd4, 32'h100,   4'd2);
    seen = 0;
    while (!bus.rsp_valid && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    if (seen >= 200) timeout_fail("stall_first_rsp");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_y",     64'(bus.rsp_y),     64'd10);
      check("stall_tag",   64'(bus.rsp_tag),   64'd1);
    end
    check("stall_go", 64'(go_cnt - g0), 64'd1);
    check("stall_state", 64'(dbg_state), 64'(ST_RESP));
    get_rsp("stall0", exp_q.pop_front(), tag_q.pop_front(), 1'b0);
    get_rsp("stall1", exp_q.pop_front(), tag_q.pop_front(), 1'b0);
    check("stall_go_total", 64'(go_cnt - g0), 64'd2);

    // reset in WAIT with one op queued
    model_lat = 12;
    send_req(FMT_LSL, 6'd2, 32'd1, 4'd3);
    seen = 0;
    while (dbg_state != ST_WAIT && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    if (seen >= 50) timeout_fail("reach_wait");
    send_req(FMT_LSL, 6'd3, 32'd1, 4'd4);
    arstn = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_state",     64'(dbg_state),     64'(ST_IDLE));
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    g0 = go_cnt;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("post_rst_no_rsp", 64'(seen), 64'd0);
    check("post_rst_no_go",  64'(go_cnt - g0), 64'd0);
    check("post_rst_ready",  64'(bus.req_ready), 64'd1);
    model_lat = 2;
    send_req(FMT_LSR, 6'd1, 32'd200, 4'd5);
    get_rsp("post_rst", 32'd100, 4'd5, 1'b0);
    check("post_rst_go", 64'(go_cnt - g0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
